// File: rtl/fetch_stage.sv
// Instruction fetch: requests aligned instruction pairs from local store, buffers them in a small FIFO
// and presents the head pair to decode. Vectors are MSB-first, so the even word is imem_rdata[63:32].
module fetch_stage #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-2:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  output logic [31:0]       first_inst,
  output logic [31:0]       second_inst,
  output logic              first_valid,
  output logic              second_valid,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

  logic [ADDR_W-2:0] fpc_q, fpc_d;
  logic              odd_q, odd_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;
  logic              ret_mask_q, ret_mask_d;
  logic [ADDR_W-2:0] ret_addr_q, ret_addr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic [63:0]       pair_mem [FIFO_DEPTH];
  logic [ADDR_W-2:0] addr_mem [FIFO_DEPTH];
  logic              mask_mem [FIFO_DEPTH];

  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occ;
  logic [63:0]      head_pair;

  assign empty     = (count_q == '0);
  assign occ       = count_q + CNT_W'(inflight_q);
  // A pop in the same cycle is not credited, so a request never outruns free space.
  assign imem_req  = reset && !redirect_valid && (occ < DEPTH_C);
  assign imem_addr = fpc_q;
  assign push      = inflight_q && !squash_q && !redirect_valid;
  assign pop       = !empty && !stall && !redirect_valid;
  assign head_pair = pair_mem[rd_ptr_q];

  always_comb begin
    fpc_d      = fpc_q;
    odd_d      = odd_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    squash_d   = redirect_valid;
    inflight_d = imem_req;
    ret_addr_d = fpc_q;
    ret_mask_d = !odd_q;
    last_pc_d  = pc_out;
    if (redirect_valid) begin
      fpc_d    = redirect_pc[ADDR_W-1:1];
      odd_d    = redirect_pc[0];
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) begin
        fpc_d = fpc_q + 1'b1;
        odd_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fpc_q      <= RESET_PC_C[ADDR_W-1:1];
      odd_q      <= RESET_PC_C[0];
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      ret_mask_q <= 1'b1;
      ret_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      last_pc_q  <= '0;
    end else begin
      fpc_q      <= fpc_d;
      odd_q      <= odd_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      ret_mask_q <= ret_mask_d;
      ret_addr_q <= ret_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      last_pc_q  <= last_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      pair_mem[wr_ptr_q] <= imem_rdata;
      addr_mem[wr_ptr_q] <= ret_addr_q;
      mask_mem[wr_ptr_q] <= ret_mask_q;
    end
  end

  assign second_valid = !empty;
  assign first_valid  = !empty && mask_mem[rd_ptr_q];
  assign first_inst   = first_valid  ? head_pair[63:32] : 32'h0;
  assign second_inst  = second_valid ? head_pair[31:0]  : 32'h0;
  assign pc_out       = empty ? last_pc_q : {addr_mem[rd_ptr_q], 1'b0};

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue of expected pairs is filled by the stimulus
// and drained by a monitor on every pop, plus cycle-exact checks of latency, stall, wrap and reset.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        imem_req;
  logic [10:0] imem_addr;
  logic [63:0] imem_rdata;
  logic [31:0] first_inst;
  logic [31:0] second_inst;
  logic        first_valid;
  logic        second_valid;
  logic [11:0] pc_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [11:0] pc;
    logic        fv;
    logic [31:0] fi;
    logic [31:0] si;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  fetch_stage #(.ADDR_W(12), .FIFO_DEPTH(4), .RESET_PC(0)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .first_inst     (first_inst),
    .second_inst    (second_inst),
    .first_valid    (first_valid),
    .second_valid   (second_valid),
    .pc_out         (pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Local store: word i holds 32'h1000_0000 + i, one-cycle read latency.
  logic [11:0] mem_wa;
  assign mem_wa = {imem_addr, 1'b0};
  always @(posedge clock) begin
    if (imem_req)
      imem_rdata <= {32'h1000_0000 + {20'h0, mem_wa}, 32'h1000_0000 + {20'h0, mem_wa} + 32'h1};
    else
      imem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_stream(input int word_pc, input int n);
    exp_t e;
    int   p;
    int   pp;
    p = word_pc >> 1;
    for (int k = 0; k < n; k++) begin
      pp   = (p + k) % 2048;
      e.pc = 12'(pp * 2);
      e.fv = !((word_pc % 2 == 1) && (k == 0));
      e.fi = e.fv ? 32'h1000_0000 + 32'(pp * 2) : 32'h0;
      e.si = 32'h1000_0000 + 32'(pp * 2 + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic redirect_to(input logic [11:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
    push_stream(int'(pc), 24);
    $display("redirect to %h", pc);
  endtask

  always @(negedge clock) begin
    if (reset && second_valid && !stall && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h first %h second %h expected no pair", pc_out, first_inst, second_inst);
      end else begin
        mon_e = exp_q.pop_front();
        $display("pop pc=%h fv=%0d first=%h second=%h", pc_out, first_valid, first_inst, second_inst);
        chk("pop_pc", 64'(pc_out), 64'(mon_e.pc));
        chk("pop_first_valid", 64'(first_valid), 64'(mon_e.fv));
        chk("pop_first", 64'(first_inst), 64'(mon_e.fi));
        chk("pop_second", 64'(second_inst), 64'(mon_e.si));
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 12'h0;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_first_valid", 64'(first_valid), 64'h0);
    chk("rst_second_valid", 64'(second_valid), 64'h0);
    chk("rst_first", 64'(first_inst), 64'h0);
    chk("rst_pc", 64'(pc_out), 64'h0);
    chk("rst_req", 64'(imem_req), 64'h0);

    // Test 1: startup latency
    push_stream(0, 64);
    reset = 1'b1;
    #1;
    chk("t1_c1_req", 64'(imem_req), 64'h1);
    chk("t1_c1_addr", 64'(imem_addr), 64'h0);
    tick();
    chk("t1_c2_empty", 64'(second_valid), 64'h0);
    tick();
    chk("t1_c3_first", 64'(first_inst), 64'h1000_0000);
    chk("t1_c3_second", 64'(second_inst), 64'h1000_0001);
    chk("t1_c3_fv", 64'(first_valid), 64'h1);
    chk("t1_c3_sv", 64'(second_valid), 64'h1);
    chk("t1_c3_pc", 64'(pc_out), 64'h0);

    // Test 2: stall for 10 cycles from cycle 4
    tick();
    stall = 1'b1;
    tick(); tick();
    chk("t2_c6_req", 64'(imem_req), 64'h0);
    repeat (3) tick();
    chk("t2_c9_req", 64'(imem_req), 64'h0);
    chk("t2_hold_first", 64'(first_inst), 64'h1000_0002);
    chk("t2_hold_second", 64'(second_inst), 64'h1000_0003);
    chk("t2_hold_pc", 64'(pc_out), 64'h2);
    repeat (5) tick();
    stall = 1'b0;
    repeat (4) tick();
    chk("t2_c18_pc", 64'(pc_out), 64'h00A);
    chk("t2_c18_first", 64'(first_inst), 64'h1000_000A);
    repeat (4) tick();

    // Test 3: even redirect mid-stream
    redirect_to(12'h00A);
    #1;
    chk("t3_n_req", 64'(imem_req), 64'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_n1_req", 64'(imem_req), 64'h1);
    chk("t3_n1_addr", 64'(imem_addr), 64'h005);
    chk("t3_n1_flushed", 64'(second_valid), 64'h0);
    tick();
    chk("t3_n2_empty", 64'(second_valid), 64'h0);
    tick();
    chk("t3_n3_first", 64'(first_inst), 64'h1000_000A);
    chk("t3_n3_second", 64'(second_inst), 64'h1000_000B);
    chk("t3_n3_pc", 64'(pc_out), 64'h00A);
    repeat (5) tick();

    // Test 4: odd redirect
    redirect_to(12'h007);
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    chk("t4_fv", 64'(first_valid), 64'h0);
    chk("t4_first", 64'(first_inst), 64'h0);
    chk("t4_sv", 64'(second_valid), 64'h1);
    chk("t4_second", 64'(second_inst), 64'h1000_0007);
    chk("t4_pc", 64'(pc_out), 64'h006);
    tick();
    chk("t4_next_fv", 64'(first_valid), 64'h1);
    chk("t4_next_first", 64'(first_inst), 64'h1000_0008);
    chk("t4_next_pc", 64'(pc_out), 64'h008);
    repeat (4) tick();

    // Test 5: address wrap
    redirect_to(12'hFFE);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t5_addr_top", 64'(imem_addr), 64'h7FF);
    tick();
    chk("t5_addr_wrap", 64'(imem_addr), 64'h000);
    chk("t5_req_wrap", 64'(imem_req), 64'h1);
    tick();
    chk("t5_first", 64'(first_inst), 64'h1000_0FFE);
    chk("t5_second", 64'(second_inst), 64'h1000_0FFF);
    chk("t5_pc", 64'(pc_out), 64'hFFE);
    tick();
    chk("t5_wrap_pc", 64'(pc_out), 64'h000);
    chk("t5_wrap_first", 64'(first_inst), 64'h1000_0000);
    repeat (3) tick();

    // Redirect together with stall
    stall = 1'b1;
    redirect_to(12'h020);
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    chk("rs_first", 64'(first_inst), 64'h1000_0020);
    chk("rs_pc", 64'(pc_out), 64'h020);
    tick();
    chk("rs_hold_pc", 64'(pc_out), 64'h020);
    stall = 1'b0;
    repeat (4) tick();

    // Back-to-back redirects: the second target wins
    redirect_to(12'h030);
    tick();
    redirect_to(12'h040);
    #1;
    chk("bb_n1_req", 64'(imem_req), 64'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("bb_addr", 64'(imem_addr), 64'h020);
    tick(); tick();
    chk("bb_first", 64'(first_inst), 64'h1000_0040);
    chk("bb_pc", 64'(pc_out), 64'h040);
    repeat (3) tick();

    // Test 6: async reset with a full FIFO under stall
    stall = 1'b1;
    repeat (6) tick();
    chk("t6_full_fv", 64'(first_valid), 64'h1);
    chk("t6_full_req", 64'(imem_req), 64'h0);
    @(posedge clock);
    #4;
    reset = 1'b0;
    #1;
    chk("t6_rst_fv", 64'(first_valid), 64'h0);
    chk("t6_rst_sv", 64'(second_valid), 64'h0);
    chk("t6_rst_first", 64'(first_inst), 64'h0);
    chk("t6_rst_second", 64'(second_inst), 64'h0);
    chk("t6_rst_pc", 64'(pc_out), 64'h0);
    chk("t6_rst_req", 64'(imem_req), 64'h0);
    chk("t6_rst_addr", 64'(imem_addr), 64'h0);
    exp_q.delete();
    stall = 1'b0;
    tick(); tick();
    push_stream(0, 16);
    reset = 1'b1;
    #1;
    chk("t6_c1_req", 64'(imem_req), 64'h1);
    chk("t6_c1_addr", 64'(imem_addr), 64'h0);
    tick(); tick();
    chk("t6_c3_first", 64'(first_inst), 64'h1000_0000);
    chk("t6_c3_second", 64'(second_inst), 64'h1000_0001);
    chk("t6_c3_pc", 64'(pc_out), 64'h0);
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
